// File: rtl/dram_rmw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dram_ctrl_pkg
// Shared definitions for the data-RAM read-modify-write controller:
//   - state_e      : controller state encoding (2 bits)
//   - DEF_AWIDTH   : default RAM address width
//   - DEF_DWIDTH   : default RAM data width
//   - byte_count() : number of byte lanes in a data word
// -----------------------------------------------------------------------------
package dram_ctrl_pkg;

    localparam int DEF_AWIDTH = 3;
    localparam int DEF_DWIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_e;

    function automatic int byte_count(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/dram_rmw_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_rmw_ctrl_if
// Bundles the request/response handshake and the RAM port of the controller.
//   slave  : controller view (consumes requests, drives RAM addr/din/we)
//   master : requester + RAM view (drives requests and ram_dout)
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_be : request channel
//   rsp_valid/rsp_rdata                                     : response pulse
//   ram_addr/ram_din/ram_we/ram_dout                        : RAM port
// -----------------------------------------------------------------------------
interface dram_rmw_ctrl_if
    import dram_ctrl_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);
    localparam int BWIDTH = byte_count(DWIDTH);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [BWIDTH-1:0] req_be;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_we
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/dram_rmw_ctrl_byte_merge.sv
// -----------------------------------------------------------------------------
// dram_byte_merge
// Combinational per-byte select between the word read from RAM and the new
// write data.
//   old_i    : word currently stored in RAM
//   new_i    : write data
//   be_i     : byte enables, bit i selects new_i[8i+7:8i]
//   merged_o : resulting word
// -----------------------------------------------------------------------------
module dram_byte_merge
    import dram_ctrl_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic [DWIDTH-1:0]               old_i,
    input  logic [DWIDTH-1:0]               new_i,
    input  logic [byte_count(DWIDTH)-1:0]   be_i,
    output logic [DWIDTH-1:0]               merged_o
);

    for (genvar i = 0; i < byte_count(DWIDTH); i++) begin : g_byte
        assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end

endmodule

// File: rtl/dram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// dram_rmw_ctrl
// Controller for one data-RAM bank (sync write, registered-address sync read).
// Reads return the stored word; byte-enabled writes are done as
// read-modify-write so unselected bytes keep their old value. Each request
// completes with a one-cycle rsp_valid pulse carrying the read or merged word.
//
// Ports:
//   clock   : rising-edge clock shared with the RAM
//   reset_n : asynchronous active-low reset
//   bus     : dram_rmw_ctrl_if.slave (request, response and RAM port)
//
// Build option:
//   DRAM_FULL_WORD_BYPASS_EN : full-word writes (all byte enables set) skip the
//                              read phase and go straight to WRITE.
// -----------------------------------------------------------------------------
module dram_rmw_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic            clock,
    input  logic            reset_n,
    dram_rmw_ctrl_if.slave  bus
);

    localparam int BWIDTH = byte_count(DWIDTH);

    state_e            state_q,     state_d;
    logic              write_q,     write_d;
    logic [DWIDTH-1:0] wdata_q,     wdata_d;
    logic [BWIDTH-1:0] be_q,        be_d;
    logic [AWIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DWIDTH-1:0] ram_din_q,   ram_din_d;
    logic              ram_we_q,    ram_we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DWIDTH-1:0] merged;

    dram_byte_merge #(
        .DWIDTH (DWIDTH)
    ) u_merge (
        .old_i    (bus.ram_dout),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                // req_ready is high only here, so req_valid alone means accept.
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    wdata_d    = bus.req_wdata;
                    be_d       = bus.req_be;
                    ram_addr_d = bus.req_addr;
                    state_d    = READ;
`ifdef DRAM_FULL_WORD_BYPASS_EN
                    // Nothing of the old word survives, so no read is needed.
                    if (bus.req_write && (&bus.req_be)) begin
                        ram_din_d   = bus.req_wdata;
                        rsp_rdata_d = bus.req_wdata;
                        ram_we_d    = 1'b1;
                        state_d     = WRITE;
                    end
`endif
                end
            end
            READ: begin
                // RAM samples ram_addr at this edge; data is usable next cycle.
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (write_q) begin
                    ram_din_d   = merged;
                    rsp_rdata_d = merged;
                    if (be_q != '0) begin
                        ram_we_d = 1'b1;
                        state_d  = WRITE;
                    end else begin
                        // Empty byte mask: report the unchanged word, skip the write.
                        rsp_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    rsp_rdata_d = bus.ram_dout;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_we    = ram_we_q;

endmodule

// File: tb/tb_dram_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_rmw_ctrl
// Bench for dram_rmw_ctrl with a behavioural sync RAM. Expected responses are
// queued when a request is driven and popped when rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dram_rmw_ctrl;
    import dram_ctrl_pkg::*;

    localparam int AW = 3;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        int            lat;
        int            wes;
    } exp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    exp_t sb_q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    dram_rmw_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    dram_rmw_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered address read, write on ram_we; not reset.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int exp_lat(input bit wr, input logic [3:0] be);
        if (!wr || be == 4'h0) return 3;
`ifdef DRAM_FULL_WORD_BYPASS_EN
        if (be == 4'hF) return 2;
`endif
        return 4;
    endfunction

    // Polls negedges after an accept edge until a response appears.
    task automatic wait_rsp();
        exp_t e;
        int   lat;
        int   wes;
        bit   got;
        lat = 0;
        wes = 0;
        got = 0;
        e   = sb_q[0];
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (bus.ram_we) begin
                wes++;
                chk("we_addr", DW'(bus.ram_addr), DW'(e.addr));
                chk("we_din", bus.ram_din, e.rdata);
            end
            if (bus.rsp_valid) begin
                got = 1;
                e = sb_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_latency", DW'(lat), DW'(e.lat));
                chk("we_pulses", DW'(wes), DW'(e.wes));
                chk("ready_with_rsp", DW'(bus.req_ready), DW'(1));
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL rsp_timeout: got no response, expected one within 12 cycles");
            void'(sb_q.pop_front());
        end
    endtask

    task automatic drive(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic [DW-1:0] exp_rd);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        e.addr  = a;
        e.rdata = exp_rd;
        e.lat   = exp_lat(wr, be);
        e.wes   = (wr && be != 4'h0) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    task automatic run_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [3:0] be, input logic [DW-1:0] exp_rd);
        @(negedge clk);
        chk("ready_idle", DW'(bus.req_ready), DW'(1));
        drive(wr, a, wd, be, exp_rd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_rsp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   guard;

        n_chk = 0;
        n_pass = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;

        vecs[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 3'd3, 32'h11223344, 4'h5, 32'hDE22BE44};
        vecs[2] = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hDE22BE44};
        vecs[3] = '{1'b1, 3'd5, 32'hABCDEF01, 4'h0, 32'h10000005};
        vecs[4] = '{1'b0, 3'd5, 32'h0,        4'h0, 32'h10000005};
        vecs[5] = '{1'b1, 3'd0, 32'hCAFEF00D, 4'hA, 32'hCA00F000};
        vecs[6] = '{1'b0, 3'd0, 32'h0,        4'h0, 32'hCA00F000};
        vecs[7] = '{1'b1, 3'd6, 32'h12345678, 4'h8, 32'h12000006};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", DW'(bus.req_ready), DW'(1));
        chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("rst_ram_we", DW'(bus.ram_we), DW'(0));
        chk("rst_ram_addr", DW'(bus.ram_addr), DW'(0));
        chk("rst_ram_din", bus.ram_din, DW'(0));
        chk("rst_rsp_rdata", bus.rsp_rdata, DW'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata);

        // Back-to-back: read held on req_valid is taken on the edge after the write response.
        @(negedge clk);
        drive(1'b1, 3'd7, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd7, 32'h0, 4'h0, 32'hA5A5A5A5);
        sb_q.pop_back();
        begin
            exp_t w;
            w = sb_q.pop_front();
            sb_q.push_back(w);
        end
        wait_rsp();
        begin
            exp_t r;
            r.addr = 3'd7; r.rdata = 32'hA5A5A5A5; r.lat = 3; r.wes = 0;
            sb_q.push_back(r);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_rsp();

        // Reset while in WRITE: the pending write must not reach the RAM.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 3'd2;
        bus.req_wdata = 32'h0;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.ram_we && guard < 8);
        chk("mid_we_seen", DW'(bus.ram_we), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", DW'(bus.ram_we), DW'(0));
        chk("mid_rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("mid_rst_ready", DW'(bus.req_ready), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_rsp", DW'(bus.rsp_valid), DW'(0));
        run_req(1'b0, 3'd2, 32'h0, 4'h0, 32'h10000002);

        // Bypass-sensitive pair: full-word then partial write to addr 1.
        run_req(1'b1, 3'd1, 32'h01020304, 4'hF, 32'h01020304);
        run_req(1'b1, 3'd1, 32'hFFFFFFFF, 4'h2, 32'h0102FF04);
        run_req(1'b0, 3'd1, 32'h0, 4'h0, 32'h0102FF04);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dram_rmw_ctrl.md
Name: dram_rmw_ctrl

Overview:
- Initiator/controller for one data-RAM bank of the 2-way set-associative cache: sync-write, sync-read RAM, word-wide write enable, one-cycle registered-address read.
- Accepts read and byte-enabled write requests from the cache hit/write-check logic.
- Drives RAM addr/din/we and performs read-modify-write so partial-byte writes never corrupt unselected bytes.
- Returns read data, or the post-write merged word, on a single-cycle response pulse.

Parameters:
- AWIDTH, 3, RAM address width; depth = 1<<AWIDTH.
- DWIDTH, 32, data width; must be a multiple of 8; BWIDTH = DWIDTH/8 (localparam).

Ports:
- clock  in  1  rising-edge clock shared with the RAM.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer occurs on req_valid && req_ready at a rising edge.
- req_write  in  1  1 = byte-enabled write, 0 = read.
- req_addr  in  AWIDTH  word address.
- req_wdata  in  DWIDTH  write data.
- req_be  in  BWIDTH  byte enables; bit i selects byte [8i+7:8i].
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  DWIDTH  read word, or merged word for writes.
- ram_addr  out  AWIDTH  RAM address (registered).
- ram_din  out  DWIDTH  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_dout  in  DWIDTH  RAM read data; valid the cycle after ram_addr has been sampled by the RAM at an edge.

Behaviour:
- Reset (async, immediate): state=IDLE; rsp_valid, ram_we = 0; ram_addr, ram_din, rsp_rdata, captured request = 0; req_ready = 1. RAM contents are not affected by reset.
- States: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - req_ready = 1.
  - On accept (edge E0): latch write/wdata/be; ram_addr <= req_addr; state <= READ.
- READ:
  - ram_we = 0; RAM samples ram_addr at E1.
  - state <= CAPTURE.
- CAPTURE: ram_dout is valid.
  - Read: rsp_rdata <= ram_dout; rsp_valid <= 1 at E2; state <= IDLE.
  - Write: merged = per byte (be[i] ? wdata byte : ram_dout byte); ram_din <= merged; rsp_rdata <= merged.
    - be != 0: ram_we <= 1; state <= WRITE.
    - be == 0: no write pulse; rsp_valid <= 1 with the old word; state <= IDLE.
- WRITE:
  - ram_we = 1 for exactly one cycle; RAM commits at E3.
  - At E3: ram_we <= 0; rsp_valid <= 1; state <= IDLE.
- rsp_valid:
  - Deasserts the cycle after it is asserted.
  - May coincide with req_ready = 1, so a new request can be accepted on the edge after the response.
- Latency from accept edge E0: read response visible after E2; RMW write response visible after E3.
- Throughput: one read per 3 cycles; one write per 4 cycles.
- Hazards:
  - ram_addr is held constant from READ through WRITE.
  - A request accepted after a write response observes the committed data (its read samples at least 2 edges after the commit).
  - Requests are never overlapped.
- req_* inputs are ignored outside IDLE.
- Reset mid-operation:
  - ram_we drops asynchronously, so a write pending in WRITE is not committed.
  - The in-flight request is dropped with no response.
- Address wrap: none; ram_addr is exactly AWIDTH bits.

Optional Feature:
- Macro: DRAM_FULL_WORD_BYPASS_EN.
- Defined: a write with be all-ones skips READ/CAPTURE.
  - At E0: ram_din <= req_wdata; rsp_rdata <= req_wdata; ram_we <= 1; state <= WRITE.
  - Response follows at E1, giving 2-cycle throughput for full-word writes.
  - Partial writes and reads are unchanged.
- Undefined: all writes use the RMW path.

Decomposition:
- Package dram_ctrl_pkg:
  - state enum (IDLE, READ, CAPTURE, WRITE) with 2-bit encoding.
  - default AWIDTH/DWIDTH constants.
  - byte-count function DWIDTH/8.
- Sub-module dram_byte_merge: combinational per-byte mux (old, new, be) -> merged, parameterized by DWIDTH.

Test Plan:
- Reset, then write addr 3, wdata 0xDEADBEEF, be 0xF -> single ram_we pulse at addr 3, ram_din 0xDEADBEEF; rsp_valid 1 cycle with rsp_rdata 0xDEADBEEF.
- Write addr 3, wdata 0x11223344, be 4'b0101 -> ram_din 0xDE22BE44; a following read of addr 3 returns 0xDE22BE44 with rsp_valid in the 3rd cycle after accept.
- Write addr 5, be 0x0 -> no ram_we pulse; rsp_rdata equals the prior word at addr 5.
- Back-to-back write addr 7 = 0xA5A5A5A5 (be 0xF), then read addr 7 held on req_valid -> read accepted on the edge of the write response; returns 0xA5A5A5A5.
- Assert reset_n = 0 during WRITE for write addr 2 = 0x0 -> ram_we falls immediately; a later read of addr 2 returns the original value; req_ready = 1 and rsp_valid = 0 after reset.
- With DRAM_FULL_WORD_BYPASS_EN: write addr 1, be 0xF -> ram_we asserted in the cycle after accept, response one edge later; partial write still takes 4 cycles.
